// File: rtl/score_display_ctrl_pkg.sv
// Shared definitions for the score display controller.
//   state_e     : controller FSM states (IDLE -> CONV -> LATCH)
//   SEG_BLANK   : active-low segment pattern with every segment off
//   DEF_*       : default sizing for the controller
//   max_score() : largest value representable in nd BCD digits
package score_display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam int         DEF_SCORE_W    = 20;
    localparam int         DEF_NUM_DIGITS = 6;
    localparam int         DEF_BLINK_DIV  = 25_000_000;

    function automatic longint max_score(input int nd);
        longint r;
        r = 1;
        for (int i = 0; i < nd; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd.sv
// Iterative binary-to-BCD converter (shift-add-3), one bit per step.
//   clk, rst_n : clock, async active-low reset
//   load       : start a conversion of din (clears accumulator and count)
//   din        : binary value to convert
//   step       : perform one iteration this cycle
//   bcd        : BCD accumulator, nibble i = decimal digit i
//   done       : high on the step that performs the final iteration
module bin2bcd_iter #(
    parameter int SCORE_W    = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [SCORE_W-1:0]        din,
    input  logic                      step,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic                      done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] sh_q,  sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   adj;
    logic               last;

    assign last = (cnt_q == CNT_W'(SCORE_W - 1));
    assign done = step && last;
    assign bcd  = bcd_q;

    always_comb begin
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        adj   = bcd_q;
        if (load) begin
            sh_d  = din;
            bcd_d = '0;
            cnt_d = '0;
        end else if (step) begin
            // Pre-correct each nibble so the doubling carries into the next digit.
            for (int i = 0; i < NUM_DIGITS; i++)
                if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            {bcd_d, sh_d} = {adj[BCD_W-2:0], sh_q, 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/score_display_ctrl_hex7seg.sv
// 4-bit hex to seven-segment decoder, active-low gfedcba.
//   nibble : value 0..F
//   seg    : segment drive, bit 0 = a ... bit 6 = g, 0 = lit
module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller for HEX0..HEX(NUM_DIGITS-1) seven-segment digits.
// Converts a strobed binary score to BCD, latches the digits, then drives
// the segments with optional leading-zero blanking and a game-over blink.
//   clk, rst_n  : clock, async active-low reset
//   score_in    : binary score, sampled when score_valid=1
//   score_valid : one-cycle load strobe
//   blank_lz    : 1 = blank digits above the highest nonzero digit
//   blink_en    : 1 = blank the whole display during the blink "off" phase
//   busy        : conversion in progress (CONV or LATCH)
//   ovf         : last converted score was clamped to 10^NUM_DIGITS-1
//   hex_out     : active-low gfedcba, digit i at [7i+6:7i], registered
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int SCORE_W    = DEF_SCORE_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int BLINK_DIV  = DEF_BLINK_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SCORE_W-1:0]      score_in,
    input  logic                    score_valid,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    ovf,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam longint MAX_VAL = max_score(NUM_DIGITS);
    localparam int     BCD_W   = 4 * NUM_DIGITS;
    localparam int     BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_e                          state_q, state_d;
    logic                            pend_vld_q, pend_vld_d;
    logic [SCORE_W-1:0]              pend_val_q, pend_val_d;
    logic                            clamp_q, clamp_d;
    logic                            ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0][3:0]      digits_q, digits_d;
    logic [BW-1:0]                   blink_cnt_q, blink_cnt_d;
    logic                            blink_ph_q, blink_ph_d;
    logic [NUM_DIGITS-1:0][6:0]      hex_q, hex_d;

    logic                            cap;
    logic [SCORE_W-1:0]              cap_val;
    logic                            clamp_hit;
    logic [SCORE_W-1:0]              load_val;
    logic                            step;
    logic                            conv_done;
    logic [BCD_W-1:0]                bcd;
    logic [NUM_DIGITS-1:0][6:0]      seg;
    logic                            lead;

    // A same-cycle strobe takes precedence over a pending value.
    assign cap       = (state_q == ST_IDLE) && (score_valid || pend_vld_q);
    assign cap_val   = score_valid ? score_in : pend_val_q;
    assign clamp_hit = 64'(cap_val) > MAX_VAL;
    assign load_val  = clamp_hit ? SCORE_W'(MAX_VAL) : cap_val;
    assign step      = (state_q == ST_CONV);

    assign busy    = (state_q != ST_IDLE);
    assign ovf     = ovf_q;
    assign hex_out = hex_q;

    bin2bcd_iter #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_b2b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cap),
        .din   (load_val),
        .step  (step),
        .bcd   (bcd),
        .done  (conv_done)
    );

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        hex7seg u_dec (
            .nibble (digits_q[i]),
            .seg    (seg[i])
        );
    end

    // FSM, pending slot and digit latch.
    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        clamp_d    = clamp_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;

        // While busy, the newest strobe replaces any earlier pending value.
        if (state_q != ST_IDLE && score_valid) begin
            pend_vld_d = 1'b1;
            pend_val_d = score_in;
        end else if (cap) begin
            pend_vld_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cap) begin
                    clamp_d = clamp_hit;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                digits_d = bcd;
                ovf_d    = clamp_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-running blink timebase.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    // Segment selection: lead stays high while every digit at or above i is zero.
    always_comb begin
        hex_d = seg;
        lead  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (digits_q[i] != 4'd0) lead = 1'b0;
            if (blank_lz && lead) hex_d[i] = SEG_BLANK;
        end
        if (blink_en && blink_ph_q) hex_d = {NUM_DIGITS{SEG_BLANK}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_vld_q  <= 1'b0;
            pend_val_q  <= '0;
            clamp_q     <= 1'b0;
            ovf_q       <= 1'b0;
            digits_q    <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            hex_q       <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_val_q  <= pend_val_d;
            clamp_q     <= clamp_d;
            ovf_q       <= ovf_d;
            digits_q    <= digits_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            hex_q       <= hex_d;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: directed stimulus, a decimal
// level reference model compared every cycle, plus literal spot checks.
module tb_score_display_ctrl;

    localparam int SW = 20;
    localparam int ND = 6;
    localparam int BD = 4;
    localparam int HW = 7 * ND;
    localparam int MAXV = 999999;
    localparam int CONV_CYC = SW + 1;

    localparam logic [HW-1:0] L_BLANK  = {ND{7'h7F}};
    localparam logic [HW-1:0] L_ZERO   = {ND{7'h40}};
    localparam logic [HW-1:0] L_1234   = {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [HW-1:0] L_1234LZ = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [HW-1:0] L_0LZ    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [HW-1:0] L_9S     = {ND{7'h10}};
    localparam logic [HW-1:0] L_5      = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12};
    localparam logic [HW-1:0] L_100    = {7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40};
    localparam logic [HW-1:0] L_300    = {7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] score_in = '0;
    logic          score_valid = 1'b0;
    logic          blank_lz = 1'b0;
    logic          blink_en = 1'b0;
    logic          busy;
    logic          ovf;
    logic [HW-1:0] hex_out;

    always #5 clk = ~clk;

    score_display_ctrl #(
        .SCORE_W    (SW),
        .NUM_DIGITS (ND),
        .BLINK_DIV  (BD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .score_in    (score_in),
        .score_valid (score_valid),
        .blank_lz    (blank_lz),
        .blink_en    (blink_en),
        .busy        (busy),
        .ovf         (ovf),
        .hex_out     (hex_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int seen200 = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [HW-1:0] render(input int v, input bit lz, input bit blk);
        logic [HW-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            if (blk || (lz && i > 0 && v < p)) r[7*i +: 7] = 7'h7F;
            else                                r[7*i +: 7] = seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    int            m_val, m_job_left, m_job_val, m_pend_val, m_bcnt, m_start_v;
    bit            m_ovf, m_job_ovf, m_pend, m_phase, m_was_busy, m_start;
    logic [HW-1:0] exp_hex = L_BLANK;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0; m_ovf = 0; m_job_left = 0; m_job_val = 0; m_job_ovf = 0;
            m_pend = 0; m_pend_val = 0; m_bcnt = 0; m_phase = 0;
            exp_hex = L_BLANK;
        end else begin
            exp_hex = render(m_val, blank_lz, blink_en && m_phase);
            m_bcnt++;
            if (m_bcnt == BD) begin m_bcnt = 0; m_phase = !m_phase; end
            m_was_busy = (m_job_left > 0);
            if (m_job_left > 0) begin
                m_job_left--;
                if (m_job_left == 0) begin m_val = m_job_val; m_ovf = m_job_ovf; end
            end
            m_start = 0;
            if (!m_was_busy) begin
                if (score_valid)  begin m_start = 1; m_start_v = int'(score_in); end
                else if (m_pend)  begin m_start = 1; m_start_v = m_pend_val; end
                m_pend = 0;
            end else if (score_valid) begin
                m_pend = 1; m_pend_val = int'(score_in);
            end
            if (m_start) begin
                m_job_ovf  = (m_start_v > MAXV);
                m_job_val  = m_job_ovf ? MAXV : m_start_v;
                m_job_left = CONV_CYC;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_hex",  64'(hex_out), 64'(exp_hex));
            check("model_busy", 64'(busy),    64'(m_job_left > 0));
            check("model_ovf",  64'(ovf),     64'(m_ovf));
        end
        if (hex_out == L_100 + 0 && 1'b0) seen200 = seen200;
        if (rst_n && !blank_lz && hex_out == {7'h40, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40})
            seen200++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic strobe(input int v);
        score_in = SW'(v);
        score_valid = 1'b1;
        step();
        score_valid = 1'b0;
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    initial begin
        int bl;
        int nb;
        wait_n(3);
        look();
        check("reset_hex",  64'(hex_out), 64'(L_BLANK));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ovf",  64'(ovf),  64'(0));
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        wait_n(3);
        look();
        check("zero_after_reset", 64'(hex_out), 64'(L_ZERO));

        // 1234 with latency / busy length
        strobe(1234);
        bl = 0;
        for (int k = 0; k < 100; k++) begin
            look();
            if (busy) bl++;
            else break;
        end
        check("busy_len", 64'(bl), 64'(21));
        wait_n(2);
        look();
        check("hex_1234", 64'(hex_out), 64'(L_1234));
        check("ovf_1234", 64'(ovf), 64'(0));

        blank_lz = 1'b1;
        step();
        look();
        check("hex_1234_lz", 64'(hex_out), 64'(L_1234LZ));
        strobe(0);
        wait_n(24);
        look();
        check("hex_0_lz", 64'(hex_out), 64'(L_0LZ));
        blank_lz = 1'b0;

        // clamp
        strobe(1048575);
        wait_n(24);
        look();
        check("hex_clamp", 64'(hex_out), 64'(L_9S));
        check("ovf_clamp", 64'(ovf), 64'(1));
        strobe(5);
        wait_n(24);
        look();
        check("hex_5", 64'(hex_out), 64'(L_5));
        check("ovf_5", 64'(ovf), 64'(0));

        // strobes while busy: last pending wins
        seen200 = 0;
        strobe(100);
        wait_n(2);
        strobe(200);
        wait_n(1);
        strobe(300);
        wait_n(19);
        look();
        check("hex_100", 64'(hex_out), 64'(L_100));
        wait_n(30);
        look();
        check("hex_300", 64'(hex_out), 64'(L_300));
        check("no_200_shown", 64'(seen200), 64'(0));

        // blink: period of 2*BD cycles, so 16 samples hold exactly 8 blank
        blink_en = 1'b1;
        step();
        nb = 0;
        for (int k = 0; k < 16; k++) begin
            look();
            if (hex_out == L_BLANK) nb++;
        end
        check("blink_blank_cnt", 64'(nb), 64'(8));
        step();
        blink_en = 1'b0;
        step();
        look();
        check("unblink", 64'(hex_out), 64'(L_300));

        // reset during a conversion
        strobe(1048575);
        wait_n(24);
        look();
        check("ovf_pre_rst", 64'(ovf), 64'(1));
        strobe(777);
        wait_n(9);
        rst_n = 1'b0;
        look();
        check("midrst_hex",  64'(hex_out), 64'(L_BLANK));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ovf",  64'(ovf),  64'(0));
        step();
        rst_n = 1'b1;
        wait_n(3);
        look();
        check("post_rst_hex",  64'(hex_out), 64'(L_ZERO));
        check("post_rst_busy", 64'(busy), 64'(0));
        wait_n(30);
        look();
        check("post_rst_hold", 64'(hex_out), 64'(L_ZERO));

        chk_en = 1'b0;
        summary();
        $finish;
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        summary();
        $finish;
    end

endmodule
